// File: rtl/dht11_data_proc.sv
// DHT11 post-processing: validates each completed read, keeps a moving average of the
// integer humidity/temperature bytes, converts the averages to BCD and tracks read errors.
module dht11_data_proc #(
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned HUM_MAX     = 95,
  parameter int unsigned TEMP_MAX    = 50,
  parameter int unsigned STALE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dht11_done,
  input  logic        dht11_valid,
  input  logic [15:0] humidity,
  input  logic [15:0] temperature,
  input  logic        clear_err,
  output logic [7:0]  hum_avg,
  output logic [7:0]  temp_avg,
  output logic [7:0]  hum_bcd,
  output logic [7:0]  temp_bcd,
  output logic        update,
  output logic        data_ok,
  output logic        stale,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = 8 + AVG_LOG2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_REJECT = 3'd2,
    S_ACCUM  = 3'd3,
    S_BCD    = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic                done_q;
  logic                valid_q,   valid_d;
  logic [7:0]          h_q,       h_d;
  logic [7:0]          t_q,       t_d;
  logic [7:0]          hbuf_q [DEPTH];
  logic [7:0]          hbuf_d [DEPTH];
  logic [7:0]          tbuf_q [DEPTH];
  logic [7:0]          tbuf_d [DEPTH];
  logic [SUM_W-1:0]    hsum_q,    hsum_d;
  logic [SUM_W-1:0]    tsum_q,    tsum_d;
  logic [AVG_LOG2-1:0] wr_ptr_q,  wr_ptr_d;
  logic                primed_q,  primed_d;
  logic [3:0]          consec_q,  consec_d;
  logic                stale_q,   stale_d;
  logic [7:0]          err_q,     err_d;
  logic [7:0]          hbin_q,    hbin_d;
  logic [7:0]          tbin_q,    tbin_d;
  logic [7:0]          hdig_q,    hdig_d;
  logic [7:0]          tdig_q,    tdig_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          hum_avg_q, hum_avg_d;
  logic [7:0]          temp_avg_q, temp_avg_d;
  logic [7:0]          hum_bcd_q, hum_bcd_d;
  logic [7:0]          temp_bcd_q, temp_bcd_d;
  logic                update_q,  update_d;
  logic                data_ok_q, data_ok_d;
  logic                busy_q,    busy_d;

  logic                trigger_c;
  logic                accept_c;
  logic [3:0]          consec_inc_c;
  logic                unused_dec;

  // Decimal bytes from the sensor are not used by this block.
  assign unused_dec = ^{humidity[7:0], temperature[7:0]};

  assign trigger_c = dht11_done & ~done_q;
  assign accept_c  = valid_q && (h_q <= 8'(HUM_MAX)) && (t_q <= 8'(TEMP_MAX));
  assign consec_inc_c = (consec_q == 4'd15) ? consec_q : 4'(consec_q + 4'd1);

  // One double-dabble step on a 2-digit BCD accumulator; hundreds carry is dropped.
  function automatic logic [15:0] dabble(input logic [7:0] dig, input logic [7:0] bin);
    logic [7:0] adj;
    adj[3:0] = (dig[3:0] >= 4'd5) ? 4'(dig[3:0] + 4'd3) : dig[3:0];
    adj[7:4] = (dig[7:4] >= 4'd5) ? 4'(dig[7:4] + 4'd3) : dig[7:4];
    return {adj[6:0], bin, 1'b0};
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (trigger_c) state_d = S_CHECK;
      S_CHECK:  state_d = accept_c ? S_ACCUM : S_REJECT;
      S_REJECT: state_d = S_IDLE;
      S_ACCUM:  state_d = S_BCD;
      S_BCD:    if (bit_cnt_q == 3'd7) state_d = S_OUT;
      S_OUT:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    valid_d    = valid_q;
    h_d        = h_q;
    t_d        = t_q;
    hbuf_d     = hbuf_q;
    tbuf_d     = tbuf_q;
    hsum_d     = hsum_q;
    tsum_d     = tsum_q;
    wr_ptr_d   = wr_ptr_q;
    primed_d   = primed_q;
    consec_d   = consec_q;
    stale_d    = stale_q;
    err_d      = err_q;
    hbin_d     = hbin_q;
    tbin_d     = tbin_q;
    hdig_d     = hdig_q;
    tdig_d     = tdig_q;
    bit_cnt_d  = bit_cnt_q;
    hum_avg_d  = hum_avg_q;
    temp_avg_d = temp_avg_q;
    hum_bcd_d  = hum_bcd_q;
    temp_bcd_d = temp_bcd_q;
    data_ok_d  = data_ok_q;
    update_d   = 1'b0;
    busy_d     = (state_d != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (trigger_c) begin
          valid_d = dht11_valid;
          h_d     = humidity[15:8];
          t_d     = temperature[15:8];
        end
      end
      S_REJECT: begin
        if (err_q != 8'hFF) err_d = 8'(err_q + 8'd1);
        consec_d = consec_inc_c;
        if (consec_inc_c >= 4'(STALE_LIMIT)) stale_d = 1'b1;
      end
      S_ACCUM: begin
        if (!primed_q) begin
          // First accepted sample fills the whole window.
          for (int i = 0; i < int'(DEPTH); i++) begin
            hbuf_d[i] = h_q;
            tbuf_d[i] = t_q;
          end
          hsum_d   = SUM_W'(h_q) << AVG_LOG2;
          tsum_d   = SUM_W'(t_q) << AVG_LOG2;
          primed_d = 1'b1;
        end else begin
          hsum_d = SUM_W'(hsum_q - SUM_W'(hbuf_q[wr_ptr_q]) + SUM_W'(h_q));
          tsum_d = SUM_W'(tsum_q - SUM_W'(tbuf_q[wr_ptr_q]) + SUM_W'(t_q));
          hbuf_d[wr_ptr_q] = h_q;
          tbuf_d[wr_ptr_q] = t_q;
          wr_ptr_d = AVG_LOG2'(wr_ptr_q + 1'b1);
        end
        hbin_d    = 8'(hsum_d >> AVG_LOG2);
        tbin_d    = 8'(tsum_d >> AVG_LOG2);
        hdig_d    = 8'd0;
        tdig_d    = 8'd0;
        bit_cnt_d = 3'd0;
        consec_d  = 4'd0;
        stale_d   = 1'b0;
      end
      S_BCD: begin
        {hdig_d, hbin_d} = dabble(hdig_q, hbin_q);
        {tdig_d, tbin_d} = dabble(tdig_q, tbin_q);
        bit_cnt_d = 3'(bit_cnt_q + 3'd1);
      end
      S_OUT: begin
        hum_avg_d  = 8'(hsum_q >> AVG_LOG2);
        temp_avg_d = 8'(tsum_q >> AVG_LOG2);
        hum_bcd_d  = hdig_q;
        temp_bcd_d = tdig_q;
        data_ok_d  = 1'b1;
        update_d   = 1'b1;
      end
      default: ;
    endcase

    // Clear has priority over a same-cycle reject increment.
    if (clear_err) err_d = 8'd0;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      h_q        <= 8'd0;
      t_q        <= 8'd0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        hbuf_q[i] <= 8'd0;
        tbuf_q[i] <= 8'd0;
      end
      hsum_q     <= '0;
      tsum_q     <= '0;
      wr_ptr_q   <= '0;
      primed_q   <= 1'b0;
      consec_q   <= 4'd0;
      stale_q    <= 1'b0;
      err_q      <= 8'd0;
      hbin_q     <= 8'd0;
      tbin_q     <= 8'd0;
      hdig_q     <= 8'd0;
      tdig_q     <= 8'd0;
      bit_cnt_q  <= 3'd0;
      hum_avg_q  <= 8'd0;
      temp_avg_q <= 8'd0;
      hum_bcd_q  <= 8'd0;
      temp_bcd_q <= 8'd0;
      update_q   <= 1'b0;
      data_ok_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q     <= dht11_done;
      valid_q    <= valid_d;
      h_q        <= h_d;
      t_q        <= t_d;
      hbuf_q     <= hbuf_d;
      tbuf_q     <= tbuf_d;
      hsum_q     <= hsum_d;
      tsum_q     <= tsum_d;
      wr_ptr_q   <= wr_ptr_d;
      primed_q   <= primed_d;
      consec_q   <= consec_d;
      stale_q    <= stale_d;
      err_q      <= err_d;
      hbin_q     <= hbin_d;
      tbin_q     <= tbin_d;
      hdig_q     <= hdig_d;
      tdig_q     <= tdig_d;
      bit_cnt_q  <= bit_cnt_d;
      hum_avg_q  <= hum_avg_d;
      temp_avg_q <= temp_avg_d;
      hum_bcd_q  <= hum_bcd_d;
      temp_bcd_q <= temp_bcd_d;
      update_q   <= update_d;
      data_ok_q  <= data_ok_d;
      busy_q     <= busy_d;
    end
  end

  assign hum_avg  = hum_avg_q;
  assign temp_avg = temp_avg_q;
  assign hum_bcd  = hum_bcd_q;
  assign temp_bcd = temp_bcd_q;
  assign update   = update_q;
  assign data_ok  = data_ok_q;
  assign stale    = stale_q;
  assign err_cnt  = err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dht11_data_proc.sv
// Bench for dht11_data_proc: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized reads.
module tb_dht11_data_proc;

  localparam int AVG_LOG2    = 2;
  localparam int DEPTH       = 1 << AVG_LOG2;
  localparam int HUM_MAX     = 95;
  localparam int TEMP_MAX    = 50;
  localparam int STALE_LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        dht11_done, dht11_valid, clear_err;
  logic [15:0] humidity, temperature;
  logic [7:0]  hum_avg, temp_avg, hum_bcd, temp_bcd, err_cnt;
  logic        update, data_ok, stale, busy;

  int total = 0;
  int bad   = 0;
  int upd_cnt = 0;

  dht11_data_proc #(
    .AVG_LOG2(AVG_LOG2), .HUM_MAX(HUM_MAX), .TEMP_MAX(TEMP_MAX), .STALE_LIMIT(STALE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .dht11_done(dht11_done), .dht11_valid(dht11_valid),
    .humidity(humidity), .temperature(temperature), .clear_err(clear_err),
    .hum_avg(hum_avg), .temp_avg(temp_avg), .hum_bcd(hum_bcd), .temp_bcd(temp_bcd),
    .update(update), .data_ok(data_ok), .stale(stale), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: counts clock edges since the accepted trigger.
  int m_hum_avg, m_temp_avg, m_hum_bcd, m_temp_bcd, m_err, m_consec;
  bit m_update, m_data_ok, m_stale, m_busy, m_active, m_done_prev, m_cv;
  int m_age, m_ch, m_ct, p_h, p_t;
  int hist_h[$];
  int hist_t[$];

  function automatic int to_bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  function automatic int mean(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s / DEPTH;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_hum_avg = 0; m_temp_avg = 0; m_hum_bcd = 0; m_temp_bcd = 0; m_err = 0;
      m_consec = 0; m_update = 0; m_data_ok = 0; m_stale = 0; m_busy = 0;
      m_active = 0; m_done_prev = 0; m_age = 0;
      hist_h.delete(); hist_t.delete();
    end else begin
      bit trig;
      m_update = 0;
      trig = dht11_done && !m_done_prev;
      m_done_prev = dht11_done;
      if (m_active) begin
        m_age++;
        if (m_age == 2) begin
          if (m_cv && m_ch <= HUM_MAX && m_ct <= TEMP_MAX) begin
            if (hist_h.size() == 0) begin
              for (int i = 0; i < DEPTH; i++) begin hist_h.push_back(m_ch); hist_t.push_back(m_ct); end
            end else begin
              hist_h.push_back(m_ch); void'(hist_h.pop_front());
              hist_t.push_back(m_ct); void'(hist_t.pop_front());
            end
            p_h = mean(hist_h); p_t = mean(hist_t);
            m_consec = 0; m_stale = 0;
          end else begin
            if (m_err < 255) m_err++;
            if (m_consec < 15) m_consec++;
            if (m_consec >= STALE_LIMIT) m_stale = 1;
            m_active = 0; m_busy = 0;
          end
        end else if (m_age == 11) begin
          m_hum_avg = p_h; m_temp_avg = p_t;
          m_hum_bcd = to_bcd(p_h); m_temp_bcd = to_bcd(p_t);
          m_update = 1; m_data_ok = 1; m_active = 0; m_busy = 0;
        end
      end else if (trig) begin
        m_active = 1; m_age = 0; m_busy = 1;
        m_cv = dht11_valid; m_ch = int'(humidity[15:8]); m_ct = int'(temperature[15:8]);
      end
      if (clear_err) m_err = 0;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("hum_avg",  int'(hum_avg),  m_hum_avg);
    chk("temp_avg", int'(temp_avg), m_temp_avg);
    chk("hum_bcd",  int'(hum_bcd),  m_hum_bcd);
    chk("temp_bcd", int'(temp_bcd), m_temp_bcd);
    chk("update",   int'(update),   int'(m_update));
    chk("data_ok",  int'(data_ok),  int'(m_data_ok));
    chk("stale",    int'(stale),    int'(m_stale));
    chk("err_cnt",  int'(err_cnt),  m_err);
    chk("busy",     int'(busy),     int'(m_busy));
    if (update) upd_cnt++;
  end

  // One read: done held for 'hold' cycles, optional clear at edge 2, re-edge at edge 4, reset.
  task automatic do_read(input bit v, input int h, input int t, input int hold,
                         input bit clr2, input bit reedge, input int rst_at);
    dht11_done  = 1'b1;
    dht11_valid = v;
    humidity    = {8'(h), 8'($urandom)};
    temperature = {8'(t), 8'($urandom)};
    for (int i = 1; i <= hold + 14; i++) begin
      @(negedge clk);
      if (i == hold) dht11_done = 1'b0;
      if (reedge && i == 3) dht11_done = 1'b0;
      if (reedge && i == 4) dht11_done = 1'b1;
      if (clr2) clear_err = (i == 2);
      if (rst_at > 0) begin
        if (i == rst_at) rst = 1'b1;
        if (i == rst_at + 2) rst = 1'b0;
      end
    end
  endtask

  initial begin
    int n0;
    rst = 1'b1; dht11_done = 1'b0; dht11_valid = 1'b0; clear_err = 1'b0;
    humidity = 16'd0; temperature = 16'd0;
    repeat (3) @(negedge clk);
    chk("reset_err",     int'(err_cnt), 0);
    chk("reset_data_ok", int'(data_ok), 0);
    chk("reset_hum_avg", int'(hum_avg), 0);
    rst = 1'b0;
    @(negedge clk);

    // Scenario 1 and 2: prime then moving average
    do_read(1, 55, 25, 2, 0, 0, 0);
    chk("s1_hum_avg", int'(hum_avg), 55);
    chk("s1_hum_bcd", int'(hum_bcd), 'h55);
    chk("s1_temp_bcd", int'(temp_bcd), 'h25);
    chk("s1_data_ok", int'(data_ok), 1);
    do_read(1, 59, 25, 2, 0, 0, 0);
    chk("s2_avg56", int'(hum_avg), 56);
    do_read(1, 63, 25, 2, 0, 0, 0);
    chk("s2_avg58", int'(hum_avg), 58);
    do_read(1, 67, 25, 2, 0, 0, 0);
    chk("s2_avg61", int'(hum_avg), 61);
    chk("s2_bcd61", int'(hum_bcd), 'h61);
    chk("s2_temp", int'(temp_avg), 25);

    // Scenario 3: stale after three rejects, cleared by accept
    n0 = upd_cnt;
    for (int k = 0; k < 3; k++) do_read(0, 61, 25, 2, 0, 0, 0);
    chk("s3_err", int'(err_cnt), 3);
    chk("s3_stale", int'(stale), 1);
    chk("s3_noupd", upd_cnt - n0, 0);
    chk("s3_hold", int'(hum_avg), 61);
    do_read(1, 61, 25, 2, 0, 0, 0);
    chk("s3_unstale", int'(stale), 0);
    chk("s3_avg62", int'(hum_avg), 62);

    // Scenario 4: range limits and error saturation
    do_read(1, 96, 25, 2, 0, 0, 0);
    chk("s4_h96", int'(err_cnt), 4);
    do_read(1, 40, 51, 2, 0, 0, 0);
    chk("s4_t51", int'(err_cnt), 5);
    n0 = upd_cnt;
    do_read(1, 95, 50, 2, 0, 0, 0);
    chk("s4_edge_ok", upd_cnt - n0, 1);
    for (int k = 0; k < 251; k++) do_read(0, 10, 10, 1, 0, 0, 0);
    chk("s4_sat", int'(err_cnt), 255);

    // Scenario 5: long level and ignored re-edge
    n0 = upd_cnt;
    do_read(1, 50, 20, 5000, 0, 0, 0);
    chk("s5_level", upd_cnt - n0, 1);
    n0 = upd_cnt;
    do_read(1, 50, 20, 20, 0, 1, 0);
    chk("s5_reedge", upd_cnt - n0, 1);

    // Scenario 6: reset during BCD, re-prime, clear vs increment
    n0 = upd_cnt;
    do_read(1, 70, 30, 2, 0, 0, 6);
    chk("s6_noupd", upd_cnt - n0, 0);
    chk("s6_hum0", int'(hum_avg), 0);
    chk("s6_bcd0", int'(temp_bcd), 0);
    chk("s6_err0", int'(err_cnt), 0);
    chk("s6_ok0", int'(data_ok), 0);
    do_read(1, 40, 22, 2, 0, 0, 0);
    chk("s6_prefill", int'(hum_avg), 40);
    chk("s6_bcd40", int'(hum_bcd), 'h40);
    do_read(0, 40, 22, 2, 0, 0, 0);
    chk("s6_err1", int'(err_cnt), 1);
    do_read(0, 40, 22, 2, 1, 0, 0);
    chk("s6_clrwins", int'(err_cnt), 0);

    // Randomized reads
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_read($urandom_range(0, 99) < 80, $urandom_range(0, 110), $urandom_range(0, 60),
              $urandom_range(1, 25), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
